// File: rtl/banked_program_memory.sv
`default_nettype none
// ============================================================================
// Module  : banked_program_memory
// Brief   : Runtime-loadable multi-bank program store with a start/stop run
//           lock, lowest-bit bank select and registered one-cycle fetch.
// Revision: 1.0 - initial release
// ============================================================================
module banked_program_memory #(
   parameter  int INSTR_WIDTH = 16,
   parameter  int ADDR_WIDTH  = 8,
   parameter  int DEPTH       = 128,
   parameter  int NUM_BANKS   = 4,
   parameter  int SEL_WIDTH   = 8,
   localparam int BANK_BITS   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SEL_WIDTH-1:0]   programSelect,
   input  logic                   start,
   input  logic                   stop,
   input  logic [ADDR_WIDTH-1:0]  address,
   input  logic                   readEnable,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instructionValid,
   output logic [BANK_BITS-1:0]   activeBank,
   output logic                   running,
   output logic                   selectError,
   input  logic                   loadValid,
   output logic                   loadReady,
   input  logic [BANK_BITS-1:0]   loadBank,
   input  logic [ADDR_WIDTH-1:0]  loadAddr,
   input  logic [INSTR_WIDTH-1:0] loadData,
   input  logic                   loadLast
);

   localparam int c_SEL_BITS   = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;
   localparam int c_DEPTH_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                   r_state;
   logic [NUM_BANKS-1:0]     r_loaded;
   logic [INSTR_WIDTH-1:0]   r_mem [NUM_BANKS][DEPTH];

   logic                     w_selFound;
   logic [c_SEL_BITS-1:0]    w_selIdx;
   logic                     w_selLoaded;
   logic                     w_startOk;
   logic                     w_fetchInRange;
   logic                     w_loadInRange;
   logic                     w_loadWrite;

   // Scan downward so the lowest set switch wins.
   always_comb begin
      w_selFound = 1'b0;
      w_selIdx   = '0;
      for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
         if (programSelect[i]) begin
            w_selFound = 1'b1;
            w_selIdx   = c_SEL_BITS'(i);
         end
      end
   end

   always_comb begin
      w_selLoaded = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_selIdx == c_SEL_BITS'(b)) begin
            w_selLoaded = r_loaded[b];
         end
      end
   end

   assign w_startOk = w_selFound
                    && ({1'b0, w_selIdx} < (c_SEL_BITS + 1)'(NUM_BANKS))
                    && w_selLoaded;

   assign w_fetchInRange = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
   assign w_loadInRange  = ({1'b0, loadBank} < (BANK_BITS + 1)'(NUM_BANKS))
                        && ({1'b0, loadAddr} < (ADDR_WIDTH + 1)'(DEPTH));

   assign running     = (r_state == S_RUN);
   assign loadReady   = !(running && (loadBank == activeBank));
   assign w_loadWrite = loadValid && loadReady && w_loadInRange;

   // Storage is deliberately left unreset; only the loaded flags are cleared.
   always_ff @(posedge clk) begin
      if (w_loadWrite) begin
         r_mem[loadBank][loadAddr[c_DEPTH_BITS-1:0]] <= loadData;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_loaded         <= '0;
         activeBank       <= '0;
         selectError      <= 1'b0;
         instruction      <= '0;
         instructionValid <= 1'b0;
      end else begin
         if (w_loadWrite) begin
            r_loaded[loadBank] <= loadLast;
         end

         instructionValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_startOk) begin
                     activeBank  <= BANK_BITS'(w_selIdx);
                     selectError <= 1'b0;
                     r_state     <= S_RUN;
                  end else begin
                     selectError <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (readEnable) begin
                  instructionValid <= 1'b1;
                  instruction      <= w_fetchInRange
                                    ? r_mem[activeBank][address[c_DEPTH_BITS-1:0]]
                                    : '0;
               end
               if (stop) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_banked_program_memory.sv
`default_nettype none
// ============================================================================
// Module  : tb_banked_program_memory
// Brief   : Table-driven directed bench for banked_program_memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_banked_program_memory;

   logic        clk;
   logic        reset;
   logic [7:0]  programSelect;
   logic        start;
   logic        stop;
   logic [7:0]  address;
   logic        readEnable;
   logic [15:0] instruction;
   logic        instructionValid;
   logic [1:0]  activeBank;
   logic        running;
   logic        selectError;
   logic        loadValid;
   logic        loadReady;
   logic [1:0]  loadBank;
   logic [7:0]  loadAddr;
   logic [15:0] loadData;
   logic        loadLast;

   int nChecks = 0;
   int nFail   = 0;

   banked_program_memory #(
      .INSTR_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(128), .NUM_BANKS(4), .SEL_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .programSelect(programSelect), .start(start),
      .stop(stop), .address(address), .readEnable(readEnable),
      .instruction(instruction), .instructionValid(instructionValid),
      .activeBank(activeBank), .running(running), .selectError(selectError),
      .loadValid(loadValid), .loadReady(loadReady), .loadBank(loadBank),
      .loadAddr(loadAddr), .loadData(loadData), .loadLast(loadLast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        st;
      logic        sp;
      logic [7:0]  sel;
      logic        re;
      logic [7:0]  addr;
      logic        lv;
      logic [1:0]  lb;
      logic [7:0]  la;
      logic [15:0] ld;
      logic        ll;
      logic        eRdy;
      logic        eRun;
      logic [1:0]  eBank;
      logic        eErr;
      logic        eVal;
      logic        cInstr;
      logic [15:0] eInstr;
   } vec_t;

   function automatic vec_t v(
      input logic st, input logic sp, input logic [7:0] sel, input logic re,
      input logic [7:0] addr, input logic lv, input logic [1:0] lb,
      input logic [7:0] la, input logic [15:0] ld, input logic ll,
      input logic eRdy, input logic eRun, input logic [1:0] eBank,
      input logic eErr, input logic eVal, input logic cInstr,
      input logic [15:0] eInstr);
      vec_t r;
      r = '{st, sp, sel, re, addr, lv, lb, la, ld, ll,
            eRdy, eRun, eBank, eErr, eVal, cInstr, eInstr};
      return r;
   endfunction

   task automatic chk(input string name, input int step,
                      input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int step);
      @(negedge clk);
      start = t.st;  stop = t.sp;  programSelect = t.sel;
      readEnable = t.re;  address = t.addr;
      loadValid = t.lv;  loadBank = t.lb;  loadAddr = t.la;
      loadData = t.ld;  loadLast = t.ll;
      #1;
      chk("loadReady", step, 32'(loadReady), 32'(t.eRdy));
      @(posedge clk);
      #1;
      chk("running", step, 32'(running), 32'(t.eRun));
      chk("activeBank", step, 32'(activeBank), 32'(t.eBank));
      chk("selectError", step, 32'(selectError), 32'(t.eErr));
      chk("instructionValid", step, 32'(instructionValid), 32'(t.eVal));
      if (t.cInstr) chk("instruction", step, 32'(instruction), 32'(t.eInstr));
   endtask

   vec_t vecs[31];

   initial begin
      //             st sp sel    re addr   lv lb la     ld        ll  rdy run bank err val ci instr
      vecs[0]  = v(0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 16'h1100, 0,  1, 0, 0, 0, 0, 1, 16'h0000);
      vecs[1]  = v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h01, 16'h0201, 0,  1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[2]  = v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h02, 16'hE000, 1,  1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[3]  = v(1, 0, 8'h01, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 0, 0, 0, 1, 16'h0000);
      vecs[4]  = v(0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  0, 1, 0, 0, 1, 1, 16'h1100);
      vecs[5]  = v(0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 16'h0000, 0,  0, 1, 0, 0, 1, 1, 16'h0201);
      vecs[6]  = v(0, 0, 8'h00, 1, 8'h02, 0, 0, 8'h00, 16'h0000, 0,  0, 1, 0, 0, 1, 1, 16'hE000);
      vecs[7]  = v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  0, 1, 0, 0, 0, 1, 16'hE000);
      vecs[8]  = v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h03, 16'h1234, 1,  0, 1, 0, 0, 0, 0, 16'h0000);
      vecs[9]  = v(0, 1, 8'h00, 1, 8'h00, 1, 0, 8'h03, 16'h1234, 1,  0, 0, 0, 0, 1, 1, 16'h1100);
      vecs[10] = v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h03, 16'h1234, 1,  1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[11] = v(0, 0, 8'h00, 0, 8'h00, 1, 2, 8'h07, 16'hBEEF, 1,  1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[12] = v(1, 0, 8'h0C, 0, 8'h00, 1, 3, 8'h00, 16'h3333, 1,  1, 1, 2, 0, 0, 0, 16'h0000);
      vecs[13] = v(0, 0, 8'h00, 1, 8'h07, 1, 3, 8'h07, 16'h7777, 1,  1, 1, 2, 0, 1, 1, 16'hBEEF);
      vecs[14] = v(0, 0, 8'h00, 1, 8'h07, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 2, 0, 1, 1, 16'hBEEF);
      vecs[15] = v(0, 0, 8'h00, 1, 8'hC8, 1, 2, 8'h01, 16'h9999, 0,  0, 1, 2, 0, 1, 1, 16'h0000);
      vecs[16] = v(0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 2, 0, 0, 0, 16'h0000);
      vecs[17] = v(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 2, 1, 0, 0, 16'h0000);
      vecs[18] = v(1, 0, 8'h10, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 2, 1, 0, 0, 16'h0000);
      vecs[19] = v(1, 0, 8'h02, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 2, 1, 0, 0, 16'h0000);
      vecs[20] = v(1, 0, 8'h02, 0, 8'h00, 1, 1, 8'h00, 16'h0101, 1,  1, 0, 2, 1, 0, 0, 16'h0000);
      vecs[21] = v(1, 0, 8'h02, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 1, 0, 0, 0, 16'h0000);
      vecs[22] = v(0, 0, 8'h00, 1, 8'h00, 1, 0, 8'hC8, 16'hDEAD, 0,  1, 1, 1, 0, 1, 1, 16'h0101);
      vecs[23] = v(0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 1, 0, 0, 0, 16'h0000);
      vecs[24] = v(1, 0, 8'h01, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 0, 0, 0, 0, 16'h0000);
      vecs[25] = v(0, 1, 8'h00, 1, 8'h03, 0, 0, 8'h00, 16'h0000, 0,  0, 0, 0, 0, 1, 1, 16'h1234);
      vecs[26] = v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h05, 16'h5555, 0,  1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[27] = v(1, 0, 8'h01, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 0, 0, 1, 0, 0, 16'h0000);
      vecs[28] = v(1, 0, 8'h08, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 3, 0, 0, 0, 16'h0000);
      vecs[29] = v(0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 3, 0, 1, 1, 16'h3333);
      vecs[30] = v(0, 0, 8'h00, 1, 8'h07, 0, 0, 8'h00, 16'h0000, 0,  1, 1, 3, 0, 1, 1, 16'h7777);

      reset = 1'b1;
      start = 1'b0;  stop = 1'b0;  programSelect = '0;
      readEnable = 1'b0;  address = '0;
      loadValid = 1'b0;  loadBank = '0;  loadAddr = '0;
      loadData = '0;  loadLast = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset running", 0, 32'(running), 32'd0);
      chk("reset instruction", 0, 32'(instruction), 32'd0);
      chk("reset valid", 0, 32'(instructionValid), 32'd0);
      chk("reset activeBank", 0, 32'(activeBank), 32'd0);
      chk("reset selectError", 0, 32'(selectError), 32'd0);
      chk("reset loadReady", 0, 32'(loadReady), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 31; i++) apply(vecs[i], i + 1);

      // Asynchronous reset in the middle of a run on bank 3.
      @(negedge clk);
      readEnable = 1'b0;  loadValid = 1'b0;  loadBank = 2'd3;
      #1;
      chk("pre-reset loadReady", 40, 32'(loadReady), 32'd0);
      #1;
      reset = 1'b1;
      #1;
      chk("async running", 40, 32'(running), 32'd0);
      chk("async instruction", 40, 32'(instruction), 32'd0);
      chk("async valid", 40, 32'(instructionValid), 32'd0);
      chk("async activeBank", 40, 32'(activeBank), 32'd0);
      chk("async loadReady", 40, 32'(loadReady), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Loaded flags were cleared, so bank 3 can no longer be started.
      apply(v(1, 0, 8'h08, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0,
              1, 0, 0, 1, 0, 1, 16'h0000), 41);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/banked_program_memory.md
# banked_program_memory

- Parametrised, runtime-loadable program store feeding the CPU fetch stage.
- Replaces fixed per-program ROM arrays with `NUM_BANKS` writable banks, each `DEPTH` words of `INSTR_WIDTH`.
- Banks are filled through a valid/ready loader port, and a start/stop state machine locks the active bank for the length of a run.
- The bank is chosen by a lowest-set-bit priority encode of the program-select switches, taken once at `start`. Fetch reads are registered, with one-cycle latency.

## Interface
- `INSTR_WIDTH`, 16, instruction word width.
- `ADDR_WIDTH`, 8, fetch/load address width.
- `DEPTH`, 128, words per bank; must be ≤ 2^`ADDR_WIDTH`.
- `NUM_BANKS`, 4, number of program banks; must be ≤ `SEL_WIDTH`. `BANK_BITS` = max(1, clog2(`NUM_BANKS`)), local.
- `SEL_WIDTH`, 8, width of the program-select switch vector.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `programSelect`  in  `SEL_WIDTH`  switch vector; sampled only on an accepted `start`.
- `start`  in  1  begin run; ignored while running.
- `stop`  in  1  end run (CPU HALT); ignored while idle.
- `address`  in  `ADDR_WIDTH`  fetch address.
- `readEnable`  in  1  fetch request.
- `instruction`  out  `INSTR_WIDTH`  registered fetch data.
- `instructionValid`  out  1  one-cycle strobe qualifying `instruction`.
- `activeBank`  out  `BANK_BITS`  bank locked for the current or last run.
- `running`  out  1  state is RUN.
- `selectError`  out  1  last `start` was rejected; sticky until the next `start`.
- `loadValid`  in  1  loader word valid.
- `loadReady`  out  1  loader word can be accepted (combinational).
- `loadBank`  in  `BANK_BITS`  target bank.
- `loadAddr`  in  `ADDR_WIDTH`  target word.
- `loadData`  in  `INSTR_WIDTH`  word to write.
- `loadLast`  in  1  final word of the bank image.

## Operation
States:
- IDLE: reset state; `running`=0.
- RUN: `running`=1.

Start (edge with `start`=1 in IDLE):
- `idx` = index of the lowest set bit of `programSelect`.
- The start is rejected if no bit is set, `idx` ≥ `NUM_BANKS`, or `loaded[idx]`=0. On reject: `selectError`←1, state stays IDLE, `activeBank` unchanged.
- Otherwise: `activeBank`←`idx`, `selectError`←0, state goes to RUN.

Stop:
- RUN → IDLE on an edge with `stop`=1.
- `start` in RUN is ignored; `stop` in IDLE is ignored.

Fetch:
- In RUN, an edge with `readEnable`=1 registers `instruction`←`mem[activeBank][address]` and sets `instructionValid`←1.
- If `address` ≥ `DEPTH`, `instruction`←0, still valid.
- With no read, `instructionValid`←0 and `instruction` holds its value.
- In IDLE, reads are ignored.

Loader:
- `loadReady` = !(`running` && `loadBank`==`activeBank`). The active bank is write-protected during a run; every other bank stays loadable.
- A word is accepted on an edge with `loadValid` && `loadReady`.
- An accepted word with `loadBank` ≥ `NUM_BANKS` or `loadAddr` ≥ `DEPTH` is consumed and dropped, with no flag changes.
- Otherwise `mem[loadBank][loadAddr]`←`loadData`, and `loaded[loadBank]` is set as follows:
  - `loadLast`=1: `loaded[loadBank]`←1.
  - `loadLast`=0: `loaded[loadBank]`←0. A partial reload invalidates the bank until its last word arrives.

Storage:
- Memory contents are not reset.
- `loaded[]` is cleared by `reset`.

## Timing
Reset values (async assert, takes effect immediately):
- `instruction`=0, `instructionValid`=0, `activeBank`=0, `running`=0, `selectError`=0, all `loaded`=0.
- State is IDLE, so `loadReady`=1.

Latency and handshakes:
- Fetch latency is 1 cycle: request at edge N, data and valid are visible after edge N.
- Back-to-back reads are sustained every cycle.
- `running` rises the cycle after an accepted `start`. A `readEnable` in the same cycle as `start` is ignored.
- A `stop` edge with `readEnable`=1 still services that read, since the state was RUN at the edge.
- Loader throughput is one word per cycle.

Simultaneous events:
- Load to the active bank while in RUN is stalled (`loadReady`=0). It is accepted the cycle after RUN→IDLE.
- A load (including `loadLast`) to bank B in the same edge as a `start` selecting B: `start` sees the pre-edge `loaded[B]`.
- Writing the address currently being read in another bank has no interaction, because banks are independent.
- Reset mid-run or mid-load aborts immediately. Partially loaded banks read as unloaded.

## Test plan
- Reset, load bank0 words 0..2 = 0x1100, 0x0201, 0xE000 with `loadLast` on word 2; `programSelect`=0x01, pulse `start`; read addr 0,1,2 on consecutive cycles → `instruction` 0x1100, 0x0201, 0xE000 each one cycle later with `instructionValid`=1; `activeBank`=0.
- `programSelect`=0x0C with bank2 loaded → `activeBank`=2; `programSelect`=0x00 → `selectError`=1, `running`=0; `programSelect`=0x10 with `NUM_BANKS`=4 → `selectError`=1.
- `start` on unloaded bank1 → `selectError`=1. Then load bank1 with `loadLast` and `start` again → `selectError`=0, `running`=1.
- In RUN on bank0: `loadValid` to bank0 → `loadReady`=0 until `stop`, then accepted. Write to bank3 in RUN → accepted immediately; bank0 fetch data unchanged.
- Read `address`=200 with `DEPTH`=128 → `instruction`=0x0000, valid=1. Load with `loadAddr`=200 → accepted, no write, `loaded` unchanged.
- Reload bank0 word 5 without `loadLast`, then `start` on bank0 → `selectError`=1. Assert `reset` mid-run → all outputs zero immediately, `running`=0.
